// File: rtl/pu_or1k_ticktimer_pkg.sv
// pu_or1k_ticktimer_pkg
// Shared definitions for the multi-channel OR1K tick timer. It holds the
// channel mode encoding, the bit positions of the TTMR control fields, the
// SPR offset of the shared prescaler register, and a helper that builds the
// mask of TTMR bits that exist for a given compare-field width.
package pu_or1k_ticktimer_pkg;

   // Channel operating mode, held in TTMR[31:30]
   typedef enum logic [1:0] {
      TT_DISABLED = 2'b00,
      TT_RESTART  = 2'b01,
      TT_STOP     = 2'b10,
      TT_CONT     = 2'b11
   } tt_mode_e;

   localparam int TTMR_MODE_HI = 31;
   localparam int TTMR_MODE_LO = 30;
   localparam int TTMR_IE_BIT  = 29;
   localparam int TTMR_IP_BIT  = 28;

   localparam logic [10:0] TTPR_OFF = 11'h010;

   // TTMR bits that are actually stored: mode, IE, IP and the period field.
   // Bits between the period field and bit 27 do not exist and read as 0.
   function automatic logic [31:0] ttmrWriteMask(input int periodW);
      return 32'hF000_0000 | ((32'h1 << periodW) - 32'h1);
   endfunction

endpackage

// File: rtl/pu_or1k_ticktimer_channel.sv
// pu_or1k_ticktimer_channel
// One compare/counter channel of the tick timer. It keeps its own TTMR and
// TTCR, advances the counter on prescaler ticks, and raises its pending flag
// whenever the counter matches the period with interrupts enabled.
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   tick_i        shared prescaler tick
//   ttmrWe_i      write strobe for this channel's TTMR
//   ttcrWe_i      write strobe for this channel's TTCR
//   wdat_i        SPR write data
//   ttmr_o        current TTMR
//   ttcr_o        current TTCR
//   irq_o         interrupt, IP & IE
module pu_or1k_ticktimer_channel
   import pu_or1k_ticktimer_pkg::*;
#(
   parameter int PERIOD_W = 28
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_i,
   input  logic        ttmrWe_i,
   input  logic        ttcrWe_i,
   input  logic [31:0] wdat_i,
   output logic [31:0] ttmr_o,
   output logic [31:0] ttcr_o,
   output logic        irq_o
);

   localparam logic [31:0] TTMR_MASK = ttmrWriteMask(PERIOD_W);

   logic [31:0] ttmr_q, ttmr_d;
   logic [31:0] ttcr_q, ttcr_d;
   tt_mode_e    mode;
   logic        periodMatch;
   logic        clearCnt;
   logic        runCnt;
   logic        setIp;

   // The match is purely combinational so it can set IP even between ticks.
   // Free-run keeps counting through a match; the other active modes stop
   // incrementing on a match (restart clears instead, stop just holds).
   assign mode        = tt_mode_e'(ttmr_q[TTMR_MODE_HI:TTMR_MODE_LO]);
   assign periodMatch = (ttcr_q[PERIOD_W-1:0] == ttmr_q[PERIOD_W-1:0]);
   assign clearCnt    = (mode == TT_RESTART) && periodMatch;
   assign runCnt      = ((mode != TT_DISABLED) && !periodMatch) || (mode == TT_CONT);
   assign setIp       = periodMatch && ttmr_q[TTMR_IE_BIT] && (mode != TT_DISABLED);

   // Counter next state: a software write always lands, otherwise the
   // counter only moves on a prescaler tick, with clear ahead of increment.
   always_comb begin
      ttcr_d = ttcr_q;
      if (ttcrWe_i) begin
         ttcr_d = wdat_i;
      end else if (tick_i) begin
         if (clearCnt) begin
            ttcr_d = '0;
         end else if (runCnt) begin
            ttcr_d = ttcr_q + 32'd1;
         end
      end
   end

   // Mode register next state: a software write wins over a same-cycle
   // pending-flag set, which is how software acknowledges an interrupt.
   always_comb begin
      ttmr_d = ttmr_q;
      if (ttmrWe_i) begin
         ttmr_d = wdat_i & TTMR_MASK;
      end else if (setIp) begin
         ttmr_d[TTMR_IP_BIT] = 1'b1;
      end
   end

   // Channel state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ttmr_q <= '0;
         ttcr_q <= '0;
      end else begin
         ttmr_q <= ttmr_d;
         ttcr_q <= ttcr_d;
      end
   end

   assign ttmr_o = ttmr_q;
   assign ttcr_o = ttcr_q;
   assign irq_o  = ttmr_q[TTMR_IP_BIT] & ttmr_q[TTMR_IE_BIT];

endmodule

// File: rtl/pu_or1k_ticktimer_multi.sv
// pu_or1k_ticktimer_multi
// Multi-channel tick timer on the SPR bus. Owns the shared prescaler, the
// SPR address decode and the read mux; each channel is a separate instance.
// Ports:
//   clk, rst       core clock, synchronous active-high reset
//   spr_access_i   SPR select for this block
//   spr_we_i       write strobe, qualified by spr_access_i
//   spr_addr_i     SPR address, offset bits [10:0] decoded
//   spr_dat_i      write data
//   spr_bus_ack    acknowledge, follows spr_access_i
//   spr_dat_o      read data, 0 when not accessed or unmapped
//   spr_ttmr_o     packed TTMR of all channels, channel i at [32i+31:32i]
//   spr_ttcr_o     packed TTCR of all channels
//   irq_o          per-channel interrupts
module pu_or1k_ticktimer_multi
   import pu_or1k_ticktimer_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int PERIOD_W = 28,
   parameter int PRESC_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spr_access_i,
   input  logic                  spr_we_i,
   input  logic [15:0]           spr_addr_i,
   input  logic [31:0]           spr_dat_i,
   output logic                  spr_bus_ack,
   output logic [31:0]           spr_dat_o,
   output logic [NUM_CH*32-1:0]  spr_ttmr_o,
   output logic [NUM_CH*32-1:0]  spr_ttcr_o,
   output logic [NUM_CH-1:0]     irq_o
);

   logic [10:0]        sprOffset;
   logic [4:0]         unusedAddrBits;
   logic               sprWrite;
   logic               ttprWe;
   logic [PRESC_W-1:0] ttpr_q, ttpr_d;
   logic [PRESC_W-1:0] pcnt_q, pcnt_d;
   logic               tick;
   logic [NUM_CH-1:0]  ttmrWe;
   logic [NUM_CH-1:0]  ttcrWe;
   logic [31:0]        chTtmr [NUM_CH];
   logic [31:0]        chTtcr [NUM_CH];
   logic [31:0]        readData;

   assign sprOffset      = spr_addr_i[10:0];
   assign unusedAddrBits = spr_addr_i[15:11];
   assign sprWrite       = spr_access_i & spr_we_i;
   assign ttprWe         = sprWrite && (sprOffset == TTPR_OFF);
   assign tick           = (pcnt_q == ttpr_q);

   // Prescaler next state: counts 0..TTPR and wraps on the tick. Reloading
   // TTPR restarts the count so a new ratio takes effect from a clean phase.
   always_comb begin
      ttpr_d = ttpr_q;
      pcnt_d = pcnt_q + PRESC_W'(1);
      if (tick) begin
         pcnt_d = '0;
      end
      if (ttprWe) begin
         ttpr_d = spr_dat_i[PRESC_W-1:0];
         pcnt_d = '0;
      end
   end

   // Prescaler registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ttpr_q <= '0;
         pcnt_q <= '0;
      end else begin
         ttpr_q <= ttpr_d;
         pcnt_q <= pcnt_d;
      end
   end

   // Channel i occupies offsets 2i (TTMR) and 2i+1 (TTCR); offsets past the
   // last channel simply match no strobe, so writes there are dropped.
   for (genvar g = 0; g < NUM_CH; g++) begin : gCh
      assign ttmrWe[g] = sprWrite && (sprOffset == 11'(2*g));
      assign ttcrWe[g] = sprWrite && (sprOffset == 11'(2*g + 1));

      pu_or1k_ticktimer_channel #(
         .PERIOD_W (PERIOD_W)
      ) uChannel (
         .clk      (clk),
         .rst      (rst),
         .tick_i   (tick),
         .ttmrWe_i (ttmrWe[g]),
         .ttcrWe_i (ttcrWe[g]),
         .wdat_i   (spr_dat_i),
         .ttmr_o   (chTtmr[g]),
         .ttcr_o   (chTtcr[g]),
         .irq_o    (irq_o[g])
      );

      assign spr_ttmr_o[32*g +: 32] = chTtmr[g];
      assign spr_ttcr_o[32*g +: 32] = chTtcr[g];
   end

   // Read mux: anything not matched, or any cycle without an access,
   // returns zero so the shared SPR read bus can OR sources together.
   always_comb begin
      readData = '0;
      if (spr_access_i) begin
         if (sprOffset == TTPR_OFF) begin
            readData = 32'(ttpr_q);
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (sprOffset == 11'(2*i)) begin
               readData = chTtmr[i];
            end else if (sprOffset == 11'(2*i + 1)) begin
               readData = chTtcr[i];
            end
         end
      end
   end

   assign spr_dat_o   = readData;
   assign spr_bus_ack = spr_access_i;

endmodule

// File: tb/tb_pu_or1k_ticktimer_multi.sv
// tb_pu_or1k_ticktimer_multi
// Bench for the multi-channel tick timer with four channels and a 16-bit
// period field. A register-level reference of the timer tracks every edge
// and a negedge process compares all outputs against it; directed sequences
// with hand-worked values pin the reference, then random SPR traffic runs.
module tb_pu_or1k_ticktimer_multi;

   localparam int NCH = 4;
   localparam int PW  = 16;
   localparam int PRW = 8;
   localparam logic [31:0] PMASK      = 32'h0000_FFFF;
   localparam logic [31:0] TTMR_WMASK = 32'hF000_FFFF;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              acc = 1'b0;
   logic              we = 1'b0;
   logic [15:0]       addr = '0;
   logic [31:0]       wdat = '0;
   logic              spr_bus_ack;
   logic [31:0]       spr_dat_o;
   logic [NCH*32-1:0] spr_ttmr_o;
   logic [NCH*32-1:0] spr_ttcr_o;
   logic [NCH-1:0]    irq_o;

   int checkCount = 0;
   int passCount  = 0;

   logic [31:0]    mTtmr [NCH];
   logic [31:0]    mTtcr [NCH];
   logic [PRW-1:0] mTtpr;
   logic [PRW-1:0] mPcnt;
   logic           modelValid = 1'b0;

   always #5 clk = ~clk;

   pu_or1k_ticktimer_multi #(
      .NUM_CH   (NCH),
      .PERIOD_W (PW),
      .PRESC_W  (PRW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .spr_access_i (acc),
      .spr_we_i     (we),
      .spr_addr_i   (addr),
      .spr_dat_i    (wdat),
      .spr_bus_ack  (spr_bus_ack),
      .spr_dat_o    (spr_dat_o),
      .spr_ttmr_o   (spr_ttmr_o),
      .spr_ttcr_o   (spr_ttcr_o),
      .irq_o        (irq_o)
   );

   task automatic checkOutput(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Reference: what an SPR access in this cycle writes, if anything
   function automatic bit wrHits(input int off);
      return acc && we && (int'(addr[10:0]) == off);
   endfunction

   function automatic logic [31:0] nextTtcr(input int i);
      logic [1:0] mode;
      bit         hit;
      mode = mTtmr[i][31:30];
      hit  = ((mTtcr[i] ^ mTtmr[i]) & PMASK) == 32'h0;
      if (wrHits(2*i + 1)) return wdat;
      if (mPcnt != mTtpr) return mTtcr[i];
      if (mode == 2'b01 && hit) return 32'h0;
      if (mode == 2'b11 || (mode != 2'b00 && !hit)) return mTtcr[i] + 32'd1;
      return mTtcr[i];
   endfunction

   function automatic logic [31:0] nextTtmr(input int i);
      logic [31:0] v;
      bit          hit;
      hit = ((mTtcr[i] ^ mTtmr[i]) & PMASK) == 32'h0;
      if (wrHits(2*i)) return wdat & TTMR_WMASK;
      v = mTtmr[i];
      if (hit && v[29] && v[31:30] != 2'b00) v[28] = 1'b1;
      return v;
   endfunction

   function automatic logic [31:0] expReadData();
      int off;
      off = int'(addr[10:0]);
      if (!acc) return 32'h0;
      if (off == 16) return {24'h0, mTtpr};
      if (off < 2*NCH) return off[0] ? mTtcr[off/2] : mTtmr[off/2];
      return 32'h0;
   endfunction

   // Reference state update at every active edge
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            mTtmr[i] <= '0;
            mTtcr[i] <= '0;
         end
         mTtpr      <= '0;
         mPcnt      <= '0;
         modelValid <= 1'b1;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            mTtmr[i] <= nextTtmr(i);
            mTtcr[i] <= nextTtcr(i);
         end
         if (wrHits(16)) begin
            mTtpr <= wdat[PRW-1:0];
            mPcnt <= '0;
         end else begin
            mPcnt <= (mPcnt == mTtpr) ? '0 : mPcnt + PRW'(1);
         end
      end
   end

   // Every-cycle comparison of all outputs against the reference
   always @(negedge clk) begin
      logic [NCH*32-1:0] expTtmr;
      logic [NCH*32-1:0] expTtcr;
      logic [NCH-1:0]    expIrq;
      if (modelValid) begin
         for (int i = 0; i < NCH; i++) begin
            expTtmr[32*i +: 32] = mTtmr[i];
            expTtcr[32*i +: 32] = mTtcr[i];
            expIrq[i]           = mTtmr[i][28] & mTtmr[i][29];
         end
         checkOutput("spr_bus_ack", spr_bus_ack, acc);
         checkOutput("spr_dat_o", spr_dat_o, expReadData());
         checkOutput("spr_ttmr_o", spr_ttmr_o, expTtmr);
         checkOutput("spr_ttcr_o", spr_ttcr_o, expTtcr);
         checkOutput("irq_o", irq_o, expIrq);
      end
   end

   // All stimulus tasks begin and end 1 time unit after a rising edge
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sprWrite(input logic [15:0] a, input logic [31:0] d);
      acc  = 1'b1;
      we   = 1'b1;
      addr = a;
      wdat = d;
      idle(1);
      acc = 1'b0;
      we  = 1'b0;
   endtask

   task automatic sprRead(input logic [15:0] a, output logic [31:0] d);
      acc  = 1'b1;
      we   = 1'b0;
      addr = a;
      @(negedge clk);
      d = spr_dat_o;
      @(posedge clk);
      #1;
      acc = 1'b0;
   endtask

   task automatic applyStimulus(input int cycles);
      logic [31:0] rnd;
      logic [10:0] off;
      int          k;
      for (int c = 0; c < cycles; c++) begin
         rnd = $urandom;
         k   = $urandom_range(0, 11);
         off = (k < 10) ? 11'(k) : (k == 10) ? 11'h010 : 11'(rnd);
         rst  = ($urandom_range(0, 99) < 2);
         acc  = ($urandom_range(0, 3) != 0);
         we   = ($urandom_range(0, 2) == 0);
         addr = {5'($urandom), off};
         if (off == 11'h010) begin
            wdat = rnd & 32'hFFFF_FF03;
         end else if (off[0] == 1'b0) begin
            wdat = rnd & 32'hFFFF_0007;
         end else begin
            wdat = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | (rnd & 32'h7))
                                               : (rnd & 32'h7);
         end
         idle(1);
      end
      rst = 1'b0;
      acc = 1'b0;
      we  = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int          offs [12];
      offs = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state: every offset reads 0
      for (int i = 0; i < 12; i++) begin
         sprRead(16'(offs[i]), d);
         checkOutput("reset read", d, 32'h0);
      end
      checkOutput("reset irq", irq_o, 4'h0);
      checkOutput("ack idle", spr_bus_ack, 1'b0);

      // Ch0 restart mode, period 5, prescaler 0
      sprWrite(16'd1, 32'h0);
      sprWrite(16'd0, 32'h6000_0005);
      idle(5);
      checkOutput("ch0 irq before match", irq_o[0], 1'b0);
      sprRead(16'd1, d);
      checkOutput("ch0 ttcr at match", d, 32'd5);
      checkOutput("ch0 irq after match", irq_o[0], 1'b1);
      checkOutput("ch0 ttcr restarted", spr_ttcr_o[31:0], 32'd0);
      sprWrite(16'd0, 32'h6000_0005);
      checkOutput("ch0 irq acked", irq_o[0], 1'b0);
      checkOutput("ch0 ttcr counting", spr_ttcr_o[31:0], 32'd1);
      sprWrite(16'd1, 32'd3);
      checkOutput("ch0 ttcr write on tick", spr_ttcr_o[31:0], 32'd3);

      // Ch3 stop mode, period 0, IE: IP set every cycle, write must win
      sprWrite(16'd7, 32'h0);
      sprWrite(16'd6, 32'hA000_0000);
      checkOutput("ch3 irq not yet", irq_o[3], 1'b0);
      idle(1);
      checkOutput("ch3 irq set", irq_o[3], 1'b1);
      sprWrite(16'd6, 32'hA000_0000);
      checkOutput("ch3 write wins irq", irq_o[3], 1'b0);
      checkOutput("ch3 write wins ttmr", spr_ttmr_o[127:96], 32'hA000_0000);
      idle(1);
      checkOutput("ch3 ttmr reset IP", spr_ttmr_o[127:96], 32'hB000_0000);
      sprWrite(16'd6, 32'h0FFF_1234);
      checkOutput("ch3 ttmr masked", spr_ttmr_o[127:96], 32'h0000_1234);

      // Prescaler 3, ch1 stop mode, period 2, IE clear
      sprWrite(16'h0010, 32'd3);
      sprWrite(16'd2, 32'h8000_0002);
      idle(2);
      checkOutput("ch1 ttcr before tick", spr_ttcr_o[63:32], 32'd0);
      idle(1);
      checkOutput("ch1 ttcr first tick", spr_ttcr_o[63:32], 32'd1);
      idle(3);
      checkOutput("ch1 ttcr between ticks", spr_ttcr_o[63:32], 32'd1);
      idle(1);
      checkOutput("ch1 ttcr second tick", spr_ttcr_o[63:32], 32'd2);
      idle(40);
      checkOutput("ch1 ttcr holds", spr_ttcr_o[63:32], 32'd2);
      checkOutput("ch1 ttmr no IP", spr_ttmr_o[63:32], 32'h8000_0002);
      checkOutput("ch1 irq", irq_o[1], 1'b0);
      sprRead(16'h0010, d);
      checkOutput("ttpr read", d, 32'd3);

      // Ch2 free-run across the 32-bit wrap, period 0
      sprWrite(16'h0010, 32'd0);
      sprWrite(16'd5, 32'hFFFF_FFFE);
      sprWrite(16'd4, 32'hE000_0000);
      checkOutput("ch2 ttcr start", spr_ttcr_o[95:64], 32'hFFFF_FFFE);
      idle(1);
      checkOutput("ch2 ttcr max", spr_ttcr_o[95:64], 32'hFFFF_FFFF);
      idle(1);
      checkOutput("ch2 ttcr wrapped", spr_ttcr_o[95:64], 32'h0);
      checkOutput("ch2 irq before", irq_o[2], 1'b0);
      idle(1);
      checkOutput("ch2 ttcr free-runs", spr_ttcr_o[95:64], 32'd1);
      checkOutput("ch2 irq set", irq_o[2], 1'b1);

      // Offsets past the last channel are unmapped
      sprWrite(16'd8, 32'h1234_5678);
      sprWrite(16'd9, 32'h0000_FFFF);
      sprRead(16'd8, d);
      checkOutput("unmapped read 8", d, 32'h0);
      sprRead(16'd9, d);
      checkOutput("unmapped read 9", d, 32'h0);
      sprRead(16'h07FF, d);
      checkOutput("unmapped read 7ff", d, 32'h0);

      // Reset mid-count with ch0 and ch1 interrupting
      sprWrite(16'd0, 32'h0);
      sprWrite(16'd2, 32'h0);
      sprWrite(16'd1, 32'h0);
      sprWrite(16'd3, 32'h0);
      sprWrite(16'd0, 32'hA000_0000);
      sprWrite(16'd2, 32'hA000_0000);
      idle(1);
      checkOutput("irq before reset", irq_o[1:0], 2'b11);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      checkOutput("irq after reset", irq_o, 4'h0);
      checkOutput("ttmr after reset", spr_ttmr_o, 128'h0);
      checkOutput("ttcr after reset", spr_ttcr_o, 128'h0);

      // Random SPR traffic against the reference
      applyStimulus(600);
      idle(2);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
